spi_rx_ctrl: RTL and testbench
==============================

// Module: spi_rx_ctrl
// PURPOSE
//  SPI mode-0 read-side controller for ILI9341 register readback (RDDID, RDDST, ...).
//  Generates SCLK, inserts an optional dummy clock and samples MISO MSB-first.
//  Assembles 1..4 bytes per transaction, with one strobe per byte and a packed 32-bit word.
//  Sits beside the write-side SPI controller; the command FSM shares SCLK/CSX via an external mux.
// PARAMETERS
//  CLK_DIV   1   SCLK half-period in clk cycles (>=1); SCLK freq = f_clk/(2*CLK_DIV)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   begin read transaction; sampled only in IDLE
//  num_bytes  in   3   bytes to receive; latched on start; 0 -> no clocks, >4 -> 4
//  dummy_en   in   1   insert one dummy SCLK period before data; latched on start
//  miso       in   1   serial data from panel (SDO)
//  sclk       out  1   registered SPI clock, idle low
//  busy       out  1   high from the cycle after accepted start until DONE completes
//  rx_data    out  8   last completed byte; holds until the next byte completes
//  rx_valid   out  1   1-cycle pulse: rx_data updated
//  rx_word    out  32  bytes shifted in left, first byte most significant; cleared on start
//  done       out  1   1-cycle pulse at end of transaction
// BEHAVIOUR
//  Reset: state=IDLE; sclk, busy, rx_valid, done = 0; rx_data = 0; rx_word = 0.
//   Reset is asynchronous and valid mid-transaction: abort immediately, sclk low, no done.
//  FSM: IDLE -> SETUP -> [DUMMY] -> SHIFT -> DONE -> IDLE.
//   IDLE:  start=1 latches num_bytes (saturated to 4) and dummy_en, clears rx_word.
//          Next state is SETUP.
//   SETUP: 1 cycle; busy=1, sclk=0.
//          Go to DUMMY if dummy_en, else SHIFT if nbytes>0, else DONE.
//   DUMMY: one full SCLK period (2*CLK_DIV cycles). MISO is ignored.
//          Then SHIFT (or DONE if nbytes=0).
//   SHIFT: 8*nbytes SCLK periods.
//   DONE:  1 cycle; done=1, busy=1, sclk=0. Return to IDLE; busy=0 from IDLE onward.
//  SCLK generation:
//   - Divider counter counts 0..CLK_DIV-1; sclk toggles when it wraps.
//   - Each period starts low for CLK_DIV cycles, then is high for CLK_DIV cycles.
//   - sclk is a flop output; no gated or combinational clock.
//   - After the last period, sclk is low on entry to DONE.
//  Sampling:
//   - On the clk edge where sclk is driven 0->1, shift miso into an 8-bit shift register (MSB first).
//   - The panel changes miso on falling edges, so miso is stable at the sample point.
//  Byte completion:
//   - A 3-bit bit counter counts samples; a 3-bit byte counter counts completed bytes.
//   - On the 8th sample: rx_data <= assembled byte; rx_word <= {rx_word[23:0], byte}.
//   - rx_valid pulses the cycle after the 8th sample. The bit counter wraps to 0.
//  Transition to DONE: when byte count == nbytes and the final high half-period has ended.
//  Latency, start accepted to done pulse:
//   - 1 (SETUP) + 2*CLK_DIV*(8*nbytes + dummy_en) + 1 clk cycles.
//   - Example: CLK_DIV=1, nbytes=1, no dummy -> done in the 18th cycle after start.
//  Boundary conditions:
//   - start while busy: ignored; no relatch.
//   - start held high: a new transaction begins only from IDLE, i.e. the cycle after DONE.
//   - nbytes=0: SETUP -> (DUMMY) -> DONE. No rx_valid; rx_word = 0.
//   - rx_valid of the last byte and the DONE pulse never share a cycle (rx_valid precedes done).
//   - miso X/Z during DUMMY must not affect any output.
// TESTING
//  1. Reset assert mid-idle -> all outputs 0, sclk low. Release -> remains IDLE with no toggles.
//  2. CLK_DIV=1, num_bytes=1, dummy_en=0, miso serialises 0xA5.
//     -> exactly 8 sclk rising edges; rx_data=0xA5; one rx_valid pulse; done 18 cycles after start.
//  3. RDDID case: num_bytes=3, dummy_en=1, bytes 0x00,0x93,0x41.
//     -> 25 rising edges; 3 rx_valid pulses with 0x00, 0x93, 0x41; rx_word=0x0000_9341.
//  4. num_bytes=5 -> 32 data edges (4 bytes). num_bytes=0 -> no sclk edges, done after SETUP.
//     start pulsed during SHIFT -> ignored.
//  5. rst low during bit 4 of byte 2 -> sclk=0 and busy=0 immediately, no done.
//     After release, a fresh 1-byte read returns correct data.
//  6. CLK_DIV=3, num_bytes=2 -> sclk high/low 3 cycles each; done 1+96+1 cycles after start;
//     bytes 0xFF,0x01 -> rx_word=0x0000_FF01.

Source files
------------

// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: SPI mode-0 read controller that optionally inserts one dummy clock, then collects 1..4 MSB-first bytes.
// Ports: clk, rst (async, active-low), start, num_bytes[2:0], dummy_en, miso ->
//        sclk (registered), busy, rx_data[7:0], rx_valid, rx_word[31:0], done.
module spi_rx_ctrl #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  num_bytes,
  input  logic        dummy_en,
  input  logic        miso,
  output logic        sclk,
  output logic        busy,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [31:0] rx_word,
  output logic        done
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, DUMMY, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] div;
  logic [2:0] nbytes, bit_cnt, byte_cnt;
  logic [7:0] shreg;
  logic dummy, active, wrap, fall, sample, byte_end;
  assign active   = state == DUMMY || state == SHIFT;
  assign wrap     = div == CW'(CLK_DIV - 1);
  assign fall     = active && wrap && sclk;
  assign sample   = state == SHIFT && wrap && !sclk;
  assign byte_end = sample && bit_cnt == 3'd7;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETUP : IDLE;
      SETUP:   state_n = dummy ? DUMMY : nbytes != 3'd0 ? SHIFT : DONE;
      DUMMY:   state_n = !fall ? DUMMY : nbytes != 3'd0 ? SHIFT : DONE;
      SHIFT:   state_n = fall && byte_cnt == nbytes ? DONE : SHIFT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div      <= '0;
      sclk     <= 1'b0;
      nbytes   <= 3'd0;
      dummy    <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
      shreg    <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_word  <= 32'd0;
    end else begin
      state    <= state_n;
      div      <= active && !wrap ? div + 1'b1 : '0;
      sclk     <= active && (wrap ? !sclk : sclk);
      rx_valid <= byte_end;
      if (state == IDLE && start) begin
        nbytes   <= num_bytes > 3'd4 ? 3'd4 : num_bytes;
        dummy    <= dummy_en;
        rx_word  <= 32'd0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 3'd0;
      end
      if (sample) begin
        shreg   <= {shreg[6:0], miso};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_end) begin
        rx_data  <= {shreg[6:0], miso};
        rx_word  <= {rx_word[23:0], shreg[6:0], miso};
        byte_cnt <= byte_cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: table-driven check of spi_rx_ctrl at CLK_DIV=1 and CLK_DIV=3, plus reset/start corner sequences.
module tb_spi_rx_ctrl;
  typedef struct {
    bit          d;
    logic [2:0]  nb;
    bit          dm;
    logic [31:0] tx;
    logic [31:0] exp_word;
    int          exp_edges;
    int          exp_bytes;
    int          exp_lat;
    bit          poke;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, dummy_en = 0;
  logic [2:0] num_bytes = 0;
  logic miso0, miso1, sclk0, sclk1, busy0, busy1, rxv0, rxv1, done0, done1;
  logic [7:0] rxd0, rxd1;
  logic [31:0] rxw0, rxw1;
  logic [31:0] tx = 0;
  bit dm_b = 0, sel = 0;
  int ec0 = 0, ec1 = 0, base0 = 0, base1 = 0;
  int n_vec = 0, n_bad = 0;
  logic s_sclk, s_busy, s_rxv, s_done;
  logic [7:0] s_rxd;
  logic [31:0] s_rxw;
  spi_rx_ctrl #(.CLK_DIV(1)) u0 (.clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .dummy_en(dummy_en),
    .miso(miso0), .sclk(sclk0), .busy(busy0), .rx_data(rxd0), .rx_valid(rxv0), .rx_word(rxw0), .done(done0));
  spi_rx_ctrl #(.CLK_DIV(3)) u1 (.clk(clk), .rst(rst), .start(start), .num_bytes(num_bytes), .dummy_en(dummy_en),
    .miso(miso1), .sclk(sclk1), .busy(busy1), .rx_data(rxd1), .rx_valid(rxv1), .rx_word(rxw1), .done(done1));
  always #5 clk = ~clk;
  always @(posedge sclk0) ec0++;
  always @(posedge sclk1) ec1++;
  function automatic logic mbit(input logic [31:0] t, input int k);
    return k < 0 ? 1'b1 : k < 32 ? t[31-k] : 1'b0;
  endfunction
  assign miso0  = mbit(tx, ec0 - base0 - int'(dm_b));
  assign miso1  = mbit(tx, ec1 - base1 - int'(dm_b));
  assign s_sclk = sel ? sclk1 : sclk0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_rxv  = sel ? rxv1 : rxv0;
  assign s_done = sel ? done1 : done0;
  assign s_rxd  = sel ? rxd1 : rxd0;
  assign s_rxw  = sel ? rxw1 : rxw0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_idle();
    int n;
    for (n = 0; n < 400 && (busy0 || busy1); n++) @(negedge clk);
    chk("idle_wait", {30'd0, busy1, busy0}, 32'd0);
  endtask
  task automatic run(input vec_t v);
    int n, nv, runs_bad, run_len, dv;
    logic prev;
    bit seen_hi, got;
    logic [7:0] eb;
    dv = v.d ? 3 : 1;
    wait_idle();
    sel = v.d;
    @(negedge clk);
    tx = v.tx; dm_b = v.dm; base0 = ec0; base1 = ec1;
    num_bytes = v.nb; dummy_en = v.dm; start = 1;
    @(posedge clk);
    #1 start = 0;
    n = 1; nv = 0; runs_bad = 0; run_len = 0; prev = 0; seen_hi = 0; got = 0;
    while (n < 400) begin
      @(negedge clk);
      if (s_sclk !== prev) begin
        if (prev || seen_hi) runs_bad += int'(run_len != dv);
        if (prev) seen_hi = 1;
        prev = s_sclk;
        run_len = 1;
      end else run_len++;
      if (s_rxv) begin
        eb = nv < 4 ? 8'(v.tx >> (24 - 8 * nv)) : 8'hxx;
        chk("rx_valid_byte", {24'd0, s_rxd}, {24'd0, eb});
        chk("valid_done_overlap", {31'd0, s_done}, 32'd0);
        nv++;
      end
      if (s_done) begin
        got = 1;
        break;
      end
      if (v.poke && n == 10) begin start = 1; num_bytes = 3'd1; dummy_en = 1; end
      if (v.poke && n == 11) start = 0;
      @(posedge clk);
      n++;
    end
    chk("latency", got ? n : -1, v.exp_lat);
    chk("rx_word", s_rxw, v.exp_word);
    chk("sclk_edges", (v.d ? ec1 - base1 : ec0 - base0), v.exp_edges);
    chk("rx_valid_count", nv, v.exp_bytes);
    chk("sclk_half_periods", runs_bad, 0);
    if (v.exp_bytes > 0) chk("rx_data_last", {24'd0, s_rxd}, {24'd0, v.exp_word[7:0]});
    @(negedge clk);
    chk("done_pulse_end", {30'd0, s_busy, s_done}, 32'd0);
  endtask
  vec_t vecs[7];
  initial begin
    int n;
    bit saw_done;
    vecs[0] = '{0, 3'd1, 0, 32'hA500_0000, 32'h0000_00A5,  8, 1, 18, 0};
    vecs[1] = '{0, 3'd3, 1, 32'h0093_4100, 32'h0000_9341, 25, 3, 52, 0};
    vecs[2] = '{0, 3'd5, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 4, 66, 1};
    vecs[3] = '{0, 3'd0, 0, 32'h0000_0000, 32'h0000_0000,  0, 0,  2, 0};
    vecs[4] = '{0, 3'd0, 1, 32'h0000_0000, 32'h0000_0000,  1, 0,  4, 0};
    vecs[5] = '{1, 3'd2, 0, 32'hFF01_0000, 32'h0000_FF01, 16, 2, 98, 0};
    vecs[6] = '{1, 3'd1, 1, 32'h3C00_0000, 32'h0000_003C,  9, 1, 56, 0};
    #3 rst = 0;
    @(negedge clk);
    chk("reset_ctrl", {28'd0, sclk0, busy0, rxv0, done0}, 32'd0);
    chk("reset_rx_data", {24'd0, rxd0}, 32'd0);
    chk("reset_rx_word", rxw0, 32'd0);
    chk("reset_ctrl_div3", {28'd0, sclk1, busy1, rxv1, done1}, 32'd0);
    @(negedge clk) rst = 1;
    repeat (6) @(negedge clk);
    chk("idle_no_edges", ec0 + ec1, 0);
    chk("idle_quiet", {29'd0, busy0, sclk0, done0}, 32'd0);
    for (int i = 0; i < 7; i++) run(vecs[i]);
    wait_idle();
    sel = 0;
    @(negedge clk);
    num_bytes = 3'd0; dummy_en = 0; start = 1;
    @(negedge clk) chk("held_setup_busy", {31'd0, busy0}, 32'd1);
    @(negedge clk) chk("held_done", {31'd0, done0}, 32'd1);
    @(negedge clk) chk("held_idle_gap", {30'd0, busy0, done0}, 32'd0);
    @(negedge clk) chk("held_restart", {31'd0, busy0}, 32'd1);
    start = 0;
    wait_idle();
    @(negedge clk);
    tx = 32'h1234_5678; dm_b = 0; base0 = ec0; base1 = ec1;
    num_bytes = 3'd2; dummy_en = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (n = 0; n < 200 && ec0 - base0 < 12; n++) @(negedge clk);
    chk("reached_byte2", ec0 - base0, 12);
    @(posedge clk);
    #2 rst = 0;
    #1 chk("async_abort", {30'd0, sclk0, busy0}, 32'd0);
    chk("abort_rx_word", rxw0, 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done0;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    rst = 1;
    run('{0, 3'd1, 0, 32'h5A00_0000, 32'h0000_005A, 8, 1, 18, 0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
